// File: rtl/activity_pkg.sv
// Shared types and defaults for the activity pulse generator: FSM state
// encoding, default rate table and parameter-range helpers.
package activity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DEF_PERIOD_W  = 20;
  localparam int DEF_PERIOD_M0 = 100000;
  localparam int DEF_PERIOD_M1 = 50000;
  localparam int DEF_PERIOD_M2 = 25000;
  localparam int DEF_PERIOD_M3 = 10000;
  localparam int DEF_PULSE_LEN = 4;
  localparam int DEF_CNT_W     = 16;

  function automatic int min4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    if (d < m) m = d;
    return m;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/period_timer.sv
// Phase counter for one pulse period: load restarts at phase 0, advance steps
// the phase, and the period value is only re-sampled when the phase wraps.
module period_timer
  import activity_pkg::*;
#(
  parameter int PERIOD_W     = DEF_PERIOD_W,
  parameter int RESET_PERIOD = DEF_PERIOD_M0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load,
  input  logic                i_advance,
  input  logic [PERIOD_W-1:0] i_period,
  output logic [PERIOD_W-1:0] o_phase,
  output logic                o_wrap
);

  logic [PERIOD_W-1:0] r_phase;
  logic [PERIOD_W-1:0] r_period;
  logic                w_wrap;

  assign w_wrap  = i_advance && (r_phase == (r_period - PERIOD_W'(1)));
  assign o_wrap  = w_wrap;
  assign o_phase = r_phase;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase  <= '0;
      r_period <= PERIOD_W'(RESET_PERIOD);
    end else if (i_load || w_wrap) begin
      r_phase  <= '0;
      r_period <= i_period;
    end else if (i_advance) begin
      r_phase  <= r_phase + 1'b1;
    end
  end

endmodule

// File: rtl/activity_pulse_gen.sv
// Rate-selectable pulse-train generator with pause, stop, optional burst
// length and a saturating count of pulses emitted since the last start.
module activity_pulse_gen
  import activity_pkg::*;
#(
  parameter int PERIOD_W  = DEF_PERIOD_W,
  parameter int PERIOD_M0 = DEF_PERIOD_M0,
  parameter int PERIOD_M1 = DEF_PERIOD_M1,
  parameter int PERIOD_M2 = DEF_PERIOD_M2,
  parameter int PERIOD_M3 = DEF_PERIOD_M3,
  parameter int PULSE_LEN = DEF_PULSE_LEN,
  parameter int BURST_LEN = 0,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       MODE,
  input  logic             START,
  input  logic             STOP,
  input  logic             PAUSE,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pulse_count,
  output logic             running,
  output logic             done
);

  localparam int     MIN_PERIOD   = min4(PERIOD_M0, PERIOD_M1, PERIOD_M2, PERIOD_M3);
  localparam int     MAX_PERIOD   = max4(PERIOD_M0, PERIOD_M1, PERIOD_M2, PERIOD_M3);
  localparam longint PERIOD_LIMIT = longint'(1) << PERIOD_W;
  localparam bit     BURST_EN     = (BURST_LEN > 0);
  localparam int     BURST_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int     BURST_LAST   = BURST_EN ? BURST_LEN - 1 : 0;

  if (MIN_PERIOD < 2 || MAX_PERIOD >= PERIOD_LIMIT || PULSE_LEN < 1 ||
      PULSE_LEN >= MIN_PERIOD || BURST_LEN < 0 || CNT_W < 1) begin : g_param_error
    $error("activity_pulse_gen: illegal period, pulse or width parameters");
  end

  state_e              r_state;
  state_e              w_state_next;
  logic [PERIOD_W-1:0] w_mode_period;
  logic [PERIOD_W-1:0] w_phase;
  logic                w_wrap;
  logic                w_load;
  logic                w_advance;
  logic                w_burst_last;
  logic                w_pulse_next;
  logic                r_pulse_out;
  logic [CNT_W-1:0]    r_pulse_count;
  logic [BURST_W-1:0]  r_burst_cnt;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_mode_period = PERIOD_W'(PERIOD_M3);
    case (MODE)
      2'd0:    w_mode_period = PERIOD_W'(PERIOD_M0);
      2'd1:    w_mode_period = PERIOD_W'(PERIOD_M1);
      2'd2:    w_mode_period = PERIOD_W'(PERIOD_M2);
      default: w_mode_period = PERIOD_W'(PERIOD_M3);
    endcase
  end

  period_timer #(
    .PERIOD_W     (PERIOD_W),
    .RESET_PERIOD (PERIOD_M0)
  ) u_period_timer (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_advance (w_advance),
    .i_period  (w_mode_period),
    .o_phase   (w_phase),
    .o_wrap    (w_wrap)
  );

  assign w_burst_last = BURST_EN && (r_burst_cnt == BURST_W'(BURST_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // STOP outranks PAUSE and burst completion; START only matters in IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (START && !STOP) w_state_next = ST_RUN;
      ST_RUN, ST_HOLD: begin
        if (STOP)                      w_state_next = ST_IDLE;
        else if (PAUSE)                w_state_next = ST_HOLD;
        else if (w_wrap && w_burst_last) w_state_next = ST_DONE;
        else                           w_state_next = ST_RUN;
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    running   = 1'b0;
    done      = 1'b0;
    w_load    = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      ST_IDLE: w_load = START && !STOP;
      ST_RUN, ST_HOLD: begin
        running   = 1'b1;
        w_advance = !STOP && !PAUSE;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // pulse_out is registered from the phase it will show next cycle.
  always_comb begin
    w_pulse_next = 1'b0;
    if (w_load) begin
      w_pulse_next = 1'b1;
    end else if (w_state_next == ST_RUN || w_state_next == ST_HOLD) begin
      if (!w_advance)  w_pulse_next = r_pulse_out;
      else if (w_wrap) w_pulse_next = 1'b1;
      else             w_pulse_next = (w_phase < PERIOD_W'(PULSE_LEN - 1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pulse_out   <= 1'b0;
      r_pulse_count <= '0;
      r_burst_cnt   <= '0;
    end else begin
      r_pulse_out <= w_pulse_next;
      if (w_load) begin
        r_pulse_count <= '0;
        r_burst_cnt   <= '0;
      end else begin
        if (w_advance && (w_phase == '0) && (r_pulse_count != {CNT_W{1'b1}}))
          r_pulse_count <= r_pulse_count + 1'b1;
        if (w_wrap)
          r_burst_cnt <= r_burst_cnt + 1'b1;
      end
    end
  end

  assign pulse_out   = r_pulse_out;
  assign pulse_count = r_pulse_count;

endmodule

// File: tb/tb_activity_pulse_gen.sv
// Bench for activity_pulse_gen: a continuous and a 5-pulse-burst instance share
// stimulus; a rule-level model is compared every cycle, plus literal anchors.
module tb_activity_pulse_gen;

  localparam int P0 = 10, P1 = 20, P2 = 40, P3 = 80;
  localparam int PL = 3;
  localparam int CMAX = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0;

  logic       c_pulse, c_running, c_done;
  logic [7:0] c_count;
  logic       b_pulse, b_running, b_done;
  logic [7:0] b_count;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;

  always #5 clk = ~clk;

  activity_pulse_gen #(
    .PERIOD_M0(P0), .PERIOD_M1(P1), .PERIOD_M2(P2), .PERIOD_M3(P3),
    .PULSE_LEN(PL), .BURST_LEN(0), .CNT_W(8)
  ) u_dut_c (
    .clk(clk), .reset(reset), .MODE(mode), .START(start), .STOP(stop), .PAUSE(pause),
    .pulse_out(c_pulse), .pulse_count(c_count), .running(c_running), .done(c_done)
  );

  activity_pulse_gen #(
    .PERIOD_M0(P0), .PERIOD_M1(P1), .PERIOD_M2(P2), .PERIOD_M3(P3),
    .PULSE_LEN(PL), .BURST_LEN(5), .CNT_W(8)
  ) u_dut_b (
    .clk(clk), .reset(reset), .MODE(mode), .START(start), .STOP(stop), .PAUSE(pause),
    .pulse_out(b_pulse), .pulse_count(b_count), .running(b_running), .done(b_done)
  );

  // Model: "active" generator with elapsed phase in the current period.
  typedef struct {
    bit active;
    bit done;
    int phase;
    int period;
    int count;
    int periods;
  } mdl_t;

  mdl_t m_c = '{default: 0};
  mdl_t m_b = '{default: 0};

  function automatic int period_of(input logic [1:0] md);
    case (md)
      2'd0:    return P0;
      2'd1:    return P1;
      2'd2:    return P2;
      default: return P3;
    endcase
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t n;
    n = '{default: 0};
    n.period = P0;
    return n;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int burst, input logic st,
                                    input logic sp, input logic pa, input logic [1:0] md);
    mdl_t n;
    n = m;
    n.done = 1'b0;
    if (!m.active) begin
      if (!m.done && st && !sp) begin
        n.active = 1'b1; n.phase = 0; n.period = period_of(md);
        n.count = 0; n.periods = 0;
      end
    end else if (sp) begin
      n.active = 1'b0;
    end else if (!pa) begin
      if (m.phase == 0) n.count = (m.count < CMAX) ? m.count + 1 : CMAX;
      n.phase = m.phase + 1;
      if (n.phase == m.period) begin
        n.phase = 0;
        n.periods = m.periods + 1;
        n.period = period_of(md);
        if (burst > 0 && n.periods == burst) begin
          n.active = 1'b0;
          n.done = 1'b1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_c = mdl_reset();
      m_b = mdl_reset();
    end else begin
      m_c = mdl_step(m_c, 0, start, stop, pause, mode);
      m_b = mdl_step(m_b, 5, start, stop, pause, mode);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("c_pulse_model",   32'(c_pulse),   32'(m_c.active && m_c.phase < PL));
    check("c_count_model",   32'(c_count),   32'(m_c.count));
    check("c_running_model", 32'(c_running), 32'(m_c.active));
    check("c_done_model",    32'(c_done),    32'(m_c.done));
    check("b_pulse_model",   32'(b_pulse),   32'(m_b.active && m_b.phase < PL));
    check("b_count_model",   32'(b_count),   32'(m_b.count));
    check("b_running_model", 32'(b_running), 32'(m_b.active));
    check("b_done_model",    32'(b_done),    32'(m_b.done));
  end

  task automatic run_to(input int t);
    while (k < t) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic start_run(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pulse", 32'(c_pulse), 0);
    check("rst_count", 32'(c_count), 0);
    check("rst_running", 32'(c_running), 0);
    check("rst_done", 32'(c_done), 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic continuous run at MODE 0; burst instance finishes after 5 periods.
    start_run(2'd0);
    check("rise_latency", 32'(c_pulse), 1);
    check("count_cleared", 32'(c_count), 0);
    run_to(2);   check("pulse_ph2", 32'(c_pulse), 1);
    run_to(3);   check("pulse_ph3", 32'(c_pulse), 0);
    run_to(9);   check("pulse_ph9", 32'(c_pulse), 0);
    run_to(10);  check("pulse_rise2", 32'(c_pulse), 1);
    run_to(50);  check("b_done_m0", 32'(b_done), 1);
                 check("b_count_m0", 32'(b_count), 5);
    run_to(51);  check("b_done_1cyc", 32'(b_done), 0);
    run_to(100); check("count_100", 32'(c_count), 10);

    // Mode change mid-period takes effect at the next wrap.
    run_to(105); mode = 2'd1;
    run_to(110); check("mode_wrap_rise", 32'(c_pulse), 1);
    run_to(120); check("mode_new_period", 32'(c_pulse), 0);
    run_to(130); check("mode_rise_20", 32'(c_pulse), 1);

    // Pause for 7 cycles at phase 2.
    run_to(152); check("count_pre_pause", 32'(c_count), 14);
    pause = 1'b1;
    run_to(159); pause = 1'b0;
    check("pause_pulse_held", 32'(c_pulse), 1);
    check("pause_count_held", 32'(c_count), 14);
    check("pause_running", 32'(c_running), 1);
    run_to(160); check("resume_ph3", 32'(c_pulse), 0);
    run_to(176); check("resume_ph19", 32'(c_pulse), 0);
    run_to(177); check("resume_rise", 32'(c_pulse), 1);

    // Stop mid-pulse, then START+STOP together in IDLE.
    stop = 1'b1; run_to(178); stop = 1'b0;
    check("stop_pulse", 32'(c_pulse), 0);
    check("stop_running", 32'(c_running), 0);
    check("stop_count_kept", 32'(c_count), 14);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("ss_idle_running", 32'(c_running), 0);
    check("ss_idle_count", 32'(c_count), 14);

    // Burst of 5 at MODE 2.
    start_run(2'd2);
    run_to(199); check("burst_not_done", 32'(b_done), 0);
                 check("burst_running", 32'(b_running), 1);
    run_to(200); check("burst_done", 32'(b_done), 1);
                 check("burst_done_idle", 32'(b_running), 0);
                 check("burst_pulse_low", 32'(b_pulse), 0);
                 check("burst_count", 32'(b_count), 5);
                 check("cont_rise_200", 32'(c_pulse), 1);
    run_to(201); check("burst_done_once", 32'(b_done), 0);
    pulse_stop();

    // STOP on the burst-completion edge suppresses done.
    start_run(2'd0);
    run_to(49); stop = 1'b1;
    run_to(50); stop = 1'b0;
    check("stopdone_done", 32'(b_done), 0);
    check("stopdone_running", 32'(b_running), 0);
    check("stopdone_count", 32'(b_count), 5);
    run_to(51); check("stopdone_later", 32'(b_done), 0);

    // Asynchronous reset between edges while the pulse is high.
    start_run(2'd0);
    run_to(1); check("pre_rst_pulse", 32'(c_pulse), 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_pulse", 32'(c_pulse), 0);
    check("async_rst_running", 32'(c_running), 0);
    check("async_rst_b_pulse", 32'(b_pulse), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_idle", 32'(c_running), 0);
    check("post_rst_pulse", 32'(c_pulse), 0);

    // Long MODE 3 run to saturate the 8-bit counter.
    start_run(2'd3);
    run_to(20320); check("sat_254", 32'(c_count), 254);
    run_to(20321); check("sat_255", 32'(c_count), 255);
    run_to(20561); check("sat_hold", 32'(c_count), 255);
    pulse_stop();

    // Randomized traffic, checked by the per-cycle model comparison.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 24) == 0);
      stop  = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 9) == 0)  pause = ~pause;
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/activity_pulse_gen.md
ACTIVITY_PULSE_GEN -- requirements
Module: activity_pulse_gen

Interface
REQ-001 Parameter PERIOD_W, default 20: width of period/phase counters.
REQ-002 Parameter PERIOD_M0..PERIOD_M3, defaults 100000, 50000, 25000, 10000: pulse period in clk cycles for MODE 0..3.
REQ-003 Parameter PULSE_LEN, default 4: pulse_out high time in clk cycles.
REQ-004 Parameter BURST_LEN, default 0: pulses per run; 0 = continuous.
REQ-005 Parameter CNT_W, default 16: pulse_count width.
REQ-006 clk  input  1  single clock, all logic rising-edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 MODE  input  2  rate select (0 slowest .. 3 fastest).
REQ-009 START  input  1  start request, single-cycle pulse.
REQ-010 STOP  input  1  stop request, single-cycle pulse.
REQ-011 PAUSE  input  1  level; hold waveform while high.
REQ-012 pulse_out  output  1  generated pulse train.
REQ-013 pulse_count  output  CNT_W  pulses emitted since last START.
REQ-014 running  output  1  high in RUN or HOLD.
REQ-015 done  output  1  one-cycle strobe at burst completion.

Function
REQ-016 FSM states: IDLE, RUN, HOLD, DONE; IDLE after reset.
REQ-017 IDLE: START=1 and STOP=0 -> RUN; phase counter cleared, pulse_count cleared, MODE latched as active period.
REQ-018 pulse_out SHALL rise the cycle after START is sampled (1-cycle latency) and is high while phase < PULSE_LEN.
REQ-019 Phase counter counts 0..period-1 in RUN, wraps to 0; pulse_out registered, glitch-free.
REQ-020 pulse_count increments by 1 on each cycle phase==0 in RUN, saturating at 2^CNT_W-1.
REQ-021 MODE changes SHALL take effect only at the next wrap (phase returns to 0); current period always completes.
REQ-022 RUN: PAUSE=1 -> HOLD; phase, pulse_out and pulse_count frozen; PAUSE=0 -> RUN, resuming from frozen phase.
REQ-023 STOP=1 in RUN or HOLD -> IDLE next cycle; pulse_out low same edge; pulse_count retained.
REQ-024 STOP has priority over START and PAUSE when simultaneous; START ignored outside IDLE.
REQ-025 BURST_LEN>0: after the BURST_LEN-th period completes (wrap), RUN -> DONE; done=1 for exactly one cycle; DONE -> IDLE.
REQ-026 STOP in same cycle as burst completion: IDLE, done stays 0.
REQ-027 Legal parameters: 2 <= PERIOD_Mx < 2^PERIOD_W, 1 <= PULSE_LEN < min(PERIOD_Mx); elaboration error otherwise.

Reset
REQ-028 reset=1 asynchronously forces IDLE, pulse_out=0, pulse_count=0, running=0, done=0, phase=0, active period=PERIOD_M0.
REQ-029 Reset asserted mid-pulse SHALL drop pulse_out immediately; START required after release to resume.

Structure
REQ-030 Shared package activity_pkg SHALL hold the FSM state enum and default period constants.
REQ-031 Sub-module period_timer (phase counter with load/hold/wrap strobe) SHALL be instantiated once.

Verification
Bench parameters: PERIOD_M0..3 = 10, 20, 40, 80; PULSE_LEN=3; CNT_W=8.
REQ-032 Reset release, START at t0, MODE=0 -> pulse_out high cycles t0+1..t0+3, rises again t0+11; after 100 cycles pulse_count=10.
REQ-033 MODE 0->1 mid-period (phase 5) -> current 10-cycle period completes, following periods 20 cycles.
REQ-034 PAUSE high 7 cycles at phase 2 -> pulse_out held high 7 extra cycles, pulse_count unchanged, phase resumes at 2.
REQ-035 BURST_LEN=5, MODE=2 -> 5 pulses, done=1 one cycle at 200 cycles after START, then IDLE, pulse_out=0, pulse_count=5.
REQ-036 START and STOP same cycle in IDLE -> stays IDLE; STOP during RUN -> pulse_out=0 next edge, running=0, count retained.
REQ-037 Async reset asserted mid-pulse between clk edges -> pulse_out=0 before next edge; counter saturation at 255 with MODE=3 long run.
